// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: 33 busy cycles from accept to commit, done one cycle later.
// A request that needs the unit while it is busy is held off by stall; independent instructions keep flowing.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hilo_read,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div;
  logic               res_neg;
  logic               rem_neg;
  logic               div_zero;

  // Issue-side operand conditioning: op[0] set means unsigned, op[1] set means divide.
  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag_in;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & src_a[WIDTH-1];
  assign b_neg     = signed_op & src_b[WIDTH-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag_in  = b_neg ? -src_b : src_b;

  // Iteration datapath; acc low half holds the multiplier / dividend bits being consumed.
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   diff;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_mag : {WIDTH{1'b0}})};
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge      = (rem_sh >= {1'b0, b_mag});
    diff    = rem_sh[WIDTH-1:0] - b_mag;
    acc_nxt = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      acc_nxt = {(ge ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end
  end

  // Sign correction and result selection applied on the commit edge.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod_fix = res_neg ? -acc : acc;
    quo_fix  = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = a_raw;
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !flush) state_nxt = CALC;
      CALC: begin
        if (flush)              state_nxt = IDLE;
        else if (cnt == '1)     state_nxt = FIX;
      end
      // A commit already under way is not squashed by flush.
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      acc      <= '0;
      b_mag    <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX);
      case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start && !flush) begin
            acc      <= {{WIDTH{1'b0}}, a_mag};
            b_mag    <= b_mag_in;
            a_raw    <= src_a;
            is_div   <= op[1];
            res_neg  <= a_neg ^ b_neg;
            rem_neg  <= op[1] & a_neg;
            div_zero <= op[1] & (src_b == '0);
            cnt      <= '0;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hilo_read | mthi | mtlo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed HI/LO results, latency, stall, flush and reset cases.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush, hilo_read, mthi, mtlo;
  logic [31:0] wdata;
  logic [31:0] hi, lo;
  logic        busy, stall, done;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .hilo_read(hilo_read), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit rd);
    int nb, nd, bad;
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0; nd = 0; bad = 0;
    while (busy && nb < 100) begin
      nb++;
      if (rd && nb == 2) hilo_read = 1'b1;
      #1;
      if (rd && nb >= 2 && stall !== 1'b1) bad++;
      if (done) nd++;
      tick();
    end
    check({tag, " busy_cycles"}, nb, 33);
    check({tag, " early_done"}, nd, 0);
    check({tag, " done"}, {31'b0, done}, 1);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    if (rd) begin
      check({tag, " stall_on_done"}, {31'b0, stall}, 0);
      check({tag, " stall_while_busy"}, bad, 0);
      hilo_read = 1'b0;
    end
    tick();
    check({tag, " done_one_cycle"}, {31'b0, done}, 0);
  endtask

  initial begin
    int nb, bad, nd;
    rst_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    flush = 1'b0; hilo_read = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    do_reset();
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", {31'b0, busy}, 0);
    check("reset done", {31'b0, done}, 0);
    check("reset stall", {31'b0, stall}, 0);

    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("mult_rd", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);

    // Flush mid-CALC; an MTLO presented while busy must stall and be dropped.
    do_reset();
    mthi = 1'b1; wdata = 32'hAAAA_5555;
    tick();
    mthi = 1'b0;
    check("mthi hi", hi, 32'hAAAA_5555);
    op = OP_MULTU; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        mtlo = 1'b1; wdata = 32'h1234_5678;
        #1;
        check("mtlo_busy stall", {31'b0, stall}, 1);
      end
      tick();
      mtlo = 1'b0;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 0);
    check("flush hi", hi, 32'hAAAA_5555);
    check("flush lo", lo, 32'h0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      tick();
    end
    check("flush no_done", nd, 0);

    // Reset mid-CALC clears HI/LO and aborts.
    mthi = 1'b1; wdata = 32'hAAAA_5555;
    tick();
    mthi = 1'b0;
    op = OP_MULTU; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid hi", hi, 0);
    check("rst_mid lo", lo, 0);
    check("rst_mid busy", {31'b0, busy}, 0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      tick();
    end
    check("rst_mid no_done", nd, 0);

    // Back-to-back start: second op held by stall until the first commits.
    op = OP_DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    tick();
    op = OP_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
    nb = 0; bad = 0;
    while (busy && nb < 100) begin
      nb++;
      #1;
      if (stall !== 1'b1) bad++;
      tick();
    end
    check("b2b first busy_cycles", nb, 33);
    check("b2b stall_while_busy", bad, 0);
    check("b2b stall_on_done", {31'b0, stall}, 0);
    check("b2b first done", {31'b0, done}, 1);
    check("b2b first hi", hi, 32'd2);
    check("b2b first lo", lo, 32'd14);
    tick();
    start = 1'b0;
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      tick();
    end
    check("b2b second busy_cycles", nb, 33);
    check("b2b second done", {31'b0, done}, 1);
    check("b2b second hi", hi, 32'h0000_0001);
    check("b2b second lo", lo, 32'hFFFF_FFFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
